// File: rtl/risc16_pkg.sv
// risc16_pkg: shared constants and types for the RiSC-16 data-memory slice.
//   DATA_W_DEF             default data word width
//   RD_LAT_MIN/RD_LAT_MAX  legal range of the load-response latency
//   dmem_state_t           controller FSM states (INIT = zero-fill sweep, RUN = serving)
package risc16_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } dmem_state_t;
endpackage

// File: rtl/dmem_ctrl_if.sv
// dmem_ctrl_if: load/store request port and load response port of dmem_ctrl.
//   req_valid/req_ready  request handshake (accepted when both high)
//   req_we               1 = store, 0 = load
//   req_addr/req_wdata   word address / store data
//   rsp_valid/rsp_rdata  one-cycle load response, no backpressure
//   init_busy            zero-fill sweep in progress
// Modports: master = load/store stage, slave = memory controller.
interface dmem_ctrl_if import risc16_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              init_busy;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, init_busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, init_busy
  );
endinterface

// File: rtl/dmem_ram.sv
// dmem_ram: single-port word array, synchronous write and synchronous
// (read-first) read, no reset.
//   clk    clock
//   we     write enable
//   addr   word index
//   wdata  write data
//   rdata  registered read data of mem[addr] as of the last edge
module dmem_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1024,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data memory for the load/store stage. After reset it sweeps
// zeros through every word (INIT), then serves one request per cycle (RUN).
// Loads answer RD_LAT cycles after acceptance, in order, with no backpressure.
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset; restarts the sweep, drops responses
//   bus    request/response port (dmem_ctrl_if.slave)
// Address bits above log2(DEPTH) are ignored, so addresses alias modulo DEPTH.
module dmem_ctrl import risc16_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  dmem_ctrl_if.slave  bus
);
  localparam int IDX_W = $clog2(DEPTH);

  generate
    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
      $error("dmem_ctrl: RD_LAT must be 1 or 2");
    end
  endgenerate

  dmem_state_t       state_q, state_d;
  logic [IDX_W-1:0]  init_cnt_q;
  logic              ready;
  logic              accept;
  logic              ld_acc;
  logic              ram_we;
  logic [IDX_W-1:0]  ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic [RD_LAT:1]   vld_pipe;

  // FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == INIT) init_cnt_q <= init_cnt_q + IDX_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    case (state_q)
      INIT: if (init_cnt_q == IDX_W'(DEPTH - 1)) state_d = RUN;
      RUN:  ready = 1'b1;
      default: state_d = INIT;
    endcase
  end

  assign bus.req_ready = ready;
  assign bus.init_busy = ~ready;

  assign accept = bus.req_valid & ready;
  assign ld_acc = accept & ~bus.req_we;

  // Write port: the sweep owns the RAM during INIT, requests own it in RUN.
  always_comb begin
    ram_we    = accept & bus.req_we;
    ram_addr  = bus.req_addr[IDX_W-1:0];
    ram_wdata = bus.req_wdata;
    if (state_q == INIT) begin
      ram_we    = 1'b1;
      ram_addr  = init_cnt_q;
      ram_wdata = '0;
    end
  end

  generate
    if (ADDR_W > IDX_W) begin : g_alias
      logic unused_addr_hi;
      assign unused_addr_hi = ^bus.req_addr[ADDR_W-1:IDX_W];
    end
  endgenerate

  dmem_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Response valid pipeline; bit 1 lines up with the RAM read register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= ld_acc;
      for (int i = 2; i <= RD_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  assign bus.rsp_valid = vld_pipe[RD_LAT];

  // Response data must read 0 after reset and hold between pulses, while the
  // RAM read register is neither reset nor stable across non-load cycles.
  generate
    if (RD_LAT == 1) begin : g_lat1
      logic [DATA_W-1:0] hold_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           hold_q <= '0;
        else if (vld_pipe[1]) hold_q <= ram_rdata;
      end
      assign bus.rsp_rdata = vld_pipe[1] ? ram_rdata : hold_q;
    end else begin : g_lat2
      logic [DATA_W-1:0] rdata_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           rdata_q <= '0;
        else if (vld_pipe[1]) rdata_q <= ram_rdata;
      end
      assign bus.rsp_rdata = rdata_q;
    end
  endgenerate
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: drives RD_LAT=1 and RD_LAT=2 instances with identical
// stimulus; a reference memory produces expected load data, which is queued
// with the cycle it is due and popped when each instance raises rsp_valid.
module tb_dmem_ctrl;
  localparam int DW    = 16;
  localparam int AW    = 16;
  localparam int DEPTH = 1024;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) if1 ();
  dmem_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) if2 ();

  dmem_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .RD_LAT(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .bus(if1));
  dmem_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .RD_LAT(2)) u_lat2 (
    .clk(clk), .rst_n(rst_n), .bus(if2));

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  logic [DW-1:0] model [DEPTH];
  exp_t q1[$], q2[$];
  exp_t e1, e2;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard, RD_LAT=1
  always @(negedge clk) begin
    if (q1.size() > 0 && q1[0].due < cyc) begin
      errors++;
      $display("FAIL lat1_missing_rsp: no rsp_valid in due cycle %0d, required rdata %h", q1[0].due, q1[0].data);
      void'(q1.pop_front());
    end
    if (if1.rsp_valid === 1'b1) begin
      vectors++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL lat1_unexpected_rsp: rsp_valid with rdata %h at cycle %0d, required none", if1.rsp_rdata, cyc);
      end else begin
        e1 = q1.pop_front();
        if (if1.rsp_rdata !== e1.data || cyc != e1.due) begin
          errors++;
          $display("FAIL lat1_rsp: got %h at cycle %0d, required %h at cycle %0d", if1.rsp_rdata, cyc, e1.data, e1.due);
        end
      end
    end
  end

  // Scoreboard, RD_LAT=2
  always @(negedge clk) begin
    if (q2.size() > 0 && q2[0].due < cyc) begin
      errors++;
      $display("FAIL lat2_missing_rsp: no rsp_valid in due cycle %0d, required rdata %h", q2[0].due, q2[0].data);
      void'(q2.pop_front());
    end
    if (if2.rsp_valid === 1'b1) begin
      vectors++;
      if (q2.size() == 0) begin
        errors++;
        $display("FAIL lat2_unexpected_rsp: rsp_valid with rdata %h at cycle %0d, required none", if2.rsp_rdata, cyc);
      end else begin
        e2 = q2.pop_front();
        if (if2.rsp_rdata !== e2.data || cyc != e2.due) begin
          errors++;
          $display("FAIL lat2_rsp: got %h at cycle %0d, required %h at cycle %0d", if2.rsp_rdata, cyc, e2.data, e2.due);
        end
      end
    end
  end

  task automatic set_req(input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if1.req_valid = v; if1.req_we = we; if1.req_addr = a; if1.req_wdata = d;
    if2.req_valid = v; if2.req_we = we; if2.req_addr = a; if2.req_wdata = d;
  endtask

  // Called at a negedge in RUN; the request is accepted at the next edge.
  task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] d);
    exp_t e;
    logic [9:0] idx;
    idx = addr[9:0];
    set_req(1'b1, we, addr, d);
    if (we) begin
      model[idx] = d;
    end else begin
      e.data = model[idx];
      e.due  = cyc + 1; q1.push_back(e);
      e.due  = cyc + 2; q2.push_back(e);
    end
    @(negedge clk);
    set_req(1'b0, 1'b0, '0, '0);
  endtask

  task automatic zero_model();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  // Called at the negedge where rst_n is released; counts busy / not-ready cycles.
  task automatic count_init(output int b1, output int b2, output int r1, output int r2);
    b1 = 0; b2 = 0; r1 = 0; r2 = 0;
    for (int i = 0; i < 2000; i++) begin
      if (if1.init_busy === 1'b1) b1++;
      if (if2.init_busy === 1'b1) b2++;
      if (if1.req_ready !== 1'b1) r1++;
      if (if2.req_ready !== 1'b1) r2++;
      if (if1.init_busy === 1'b0 && if2.init_busy === 1'b0) break;
      @(negedge clk);
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((q1.size() > 0 || q2.size() > 0) && n < 10) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (q1.size() > 0 || q2.size() > 0) begin
      errors++;
      $display("FAIL %s_drain: %0d/%0d responses outstanding, required 0/0", name, q1.size(), q2.size());
      q1.delete(); q2.delete();
    end
  endtask

  task automatic test_reset();
    int b1, b2, r1, r2;
    @(negedge clk);
    rst_n = 1'b0;
    q1.delete(); q2.delete();
    repeat (3) @(negedge clk);
    vectors += 8;
    if (if1.req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready1: got %b, required 0", if1.req_ready); end
    if (if2.req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready2: got %b, required 0", if2.req_ready); end
    if (if1.init_busy !== 1'b1) begin errors++; $display("FAIL rst_busy1: got %b, required 1", if1.init_busy); end
    if (if2.init_busy !== 1'b1) begin errors++; $display("FAIL rst_busy2: got %b, required 1", if2.init_busy); end
    if (if1.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rvalid1: got %b, required 0", if1.rsp_valid); end
    if (if2.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rvalid2: got %b, required 0", if2.rsp_valid); end
    if (if1.rsp_rdata !== 16'h0000) begin errors++; $display("FAIL rst_rdata1: got %h, required 0000", if1.rsp_rdata); end
    if (if2.rsp_rdata !== 16'h0000) begin errors++; $display("FAIL rst_rdata2: got %h, required 0000", if2.rsp_rdata); end
    rst_n = 1'b1;
    count_init(b1, b2, r1, r2);
    vectors += 4;
    if (b1 != DEPTH) begin errors++; $display("FAIL init_busy_len1: got %0d cycles, required %0d", b1, DEPTH); end
    if (b2 != DEPTH) begin errors++; $display("FAIL init_busy_len2: got %0d cycles, required %0d", b2, DEPTH); end
    if (r1 != DEPTH) begin errors++; $display("FAIL init_notready_len1: got %0d cycles, required %0d", r1, DEPTH); end
    if (r2 != DEPTH) begin errors++; $display("FAIL init_notready_len2: got %0d cycles, required %0d", r2, DEPTH); end
    zero_model();
    issue(1'b0, 16'h0000, '0);
    issue(1'b0, 16'h0010, '0);
    issue(1'b0, 16'hABCD, '0);
    issue(1'b0, 16'hFFFF, '0);
    drain("reset");
  endtask

  task automatic test_write_read();
    issue(1'b1, 16'h0000, 16'hAAAA);
    issue(1'b1, 16'h0010, 16'h0014);
    issue(1'b1, 16'hABCD, 16'hDEAD);
    issue(1'b1, 16'hFFFF, 16'h5555);
    issue(1'b0, 16'h0000, '0);
    issue(1'b0, 16'h0010, '0);
    issue(1'b0, 16'hABCD, '0);
    issue(1'b0, 16'hFFFF, '0);
    drain("write_read");
  endtask

  task automatic test_alias();
    issue(1'b1, 16'h03FF, 16'h1234);
    issue(1'b0, 16'hFFFF, '0);
    issue(1'b1, 16'h0010, 16'hBEEF);
    issue(1'b0, 16'h0410, '0);
    drain("alias");
  endtask

  task automatic test_back_to_back();
    issue(1'b1, 16'h0005, 16'h0001);
    issue(1'b0, 16'h0005, '0);
    issue(1'b0, 16'h0006, '0);
    drain("b2b");
    // load then store to the same word: the load sees the old value
    issue(1'b0, 16'h0005, '0);
    issue(1'b1, 16'h0005, 16'h0002);
    issue(1'b0, 16'h0005, '0);
    drain("ld_st");
  endtask

  task automatic test_overwrite();
    issue(1'b1, 16'h0000, 16'hAAAB);
    issue(1'b1, 16'h0010, 16'h0015);
    issue(1'b1, 16'hABCD, 16'hDEAE);
    issue(1'b1, 16'hFFFF, 16'h5556);
    issue(1'b0, 16'h0000, '0);
    issue(1'b0, 16'h0010, '0);
    issue(1'b0, 16'hABCD, '0);
    issue(1'b0, 16'hFFFF, '0);
    drain("overwrite");
  endtask

  task automatic test_mid_reset();
    int b1, b2, r1, r2;
    issue(1'b1, 16'h0010, 16'h7777);
    set_req(1'b1, 1'b0, 16'h0010, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    q1.delete(); q2.delete();
    set_req(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    vectors += 2;
    if (if1.rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_rvalid1: got %b, required 0", if1.rsp_valid); end
    if (if2.rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_rvalid2: got %b, required 0", if2.rsp_valid); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    count_init(b1, b2, r1, r2);
    vectors += 2;
    if (b1 != DEPTH) begin errors++; $display("FAIL midrst_busy_len1: got %0d cycles, required %0d", b1, DEPTH); end
    if (b2 != DEPTH) begin errors++; $display("FAIL midrst_busy_len2: got %0d cycles, required %0d", b2, DEPTH); end
    zero_model();
    issue(1'b0, 16'h0010, '0);
    drain("mid_reset");
  endtask

  initial begin
    set_req(1'b0, 1'b0, '0, '0);
    zero_model();
    test_reset();
    test_write_read();
    test_alias();
    test_back_to_back();
    test_overwrite();
    test_mid_reset();
    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
